// File: rtl/encoder4to2_pending_pkg.sv
// rtl/encoder4to2_pending_pkg.sv - shared state encodings and defaults for the pending encoder
package encoder4to2_pending_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int DROP_W_DEF = 8;

endpackage

// File: rtl/encoder4to2_pending_decoder2to4.sv
// rtl/encoder4to2_pending_decoder2to4.sv - 2-to-4 one-hot line decoder with enable
module decoder2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = 4'b0000;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/encoder4to2_pending_pri_enc4.sv
// rtl/encoder4to2_pending_pri_enc4.sv - combinational 4-input priority encoder, selectable order
module pri_enc4 #(
    parameter bit HIGH_WINS = 1'b1
) (
    input  logic [3:0] in,
    output logic [1:0] out,
    output logic       any
);

    always_comb begin
        out = 2'd0;
        any = |in;
        if (HIGH_WINS) begin
            if (in[3])      out = 2'd3;
            else if (in[2]) out = 2'd2;
            else if (in[1]) out = 2'd1;
            else            out = 2'd0;
        end else begin
            if (in[0])      out = 2'd0;
            else if (in[1]) out = 2'd1;
            else if (in[2]) out = 2'd2;
            else if (in[3]) out = 2'd3;
            else            out = 2'd0;
        end
    end

endmodule

// File: rtl/encoder4to2_pending.sv
// rtl/encoder4to2_pending.sv - sticky request capture, masked priority selection, valid/ready index output
module encoder4to2_pending
    import encoder4to2_pending_pkg::*;
#(
    parameter bit HIGH_WINS = 1'b1,
    parameter int DROP_W    = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [3:0]        mask,
    input  logic              ready,
    output logic              valid,
    output logic [1:0]        code,
    output logic [3:0]        pending,
    output logic              drop,
    output logic [DROP_W-1:0] drop_cnt
);

    state_t      state_q, state_d;
    logic [1:0]  code_d;
    logic        fire;
    logic [3:0]  clr;
    logic [3:0]  pending_d;
    logic [3:0]  eligible;
    logic [1:0]  sel;
    logic        sel_any;
    logic        drop_evt;

    assign fire = valid & ready;

    decoder2to4 u_clr_dec (
        .sel    (code),
        .en     (fire),
        .onehot (clr)
    );

    // req is ORed in after the clear so a re-arriving event on the acknowledged bit survives
    assign pending_d = (pending & ~clr) | req;
    assign eligible  = pending_d & ~mask;
    assign drop_evt  = |(req & pending & ~clr);

    pri_enc4 #(.HIGH_WINS(HIGH_WINS)) u_sel (
        .in  (eligible),
        .out (sel),
        .any (sel_any)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code;
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    code_d  = sel;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // held code only moves on a handshake, never on new arrivals or mask edits
                if (fire) begin
                    if (sel_any) code_d = sel;
                    else         state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign valid = (state_q == ST_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            code     <= 2'd0;
            pending  <= 4'b0000;
            drop     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state_q <= state_d;
            code    <= code_d;
            pending <= pending_d;
            drop    <= drop_evt;
            if (drop_evt && (drop_cnt != {DROP_W{1'b1}}))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
